// File: rtl/reg_status_alu_if.sv
// Bundle for the register status table: lookup, rename write, result broadcast and ALU operands.
interface reg_status_alu_if #(
  parameter int unsigned IDX_W  = 6,
  parameter int unsigned UNIT_W = 8,
  parameter int unsigned WORD_W = 32
);
  logic [IDX_W-1:0]  rd_idx;
  logic [UNIT_W-1:0] rd_tag;
  logic [WORD_W-1:0] rd_val;

  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;
  logic [UNIT_W-1:0] wr_tag;
  logic [WORD_W-1:0] wr_val;

  logic              cdb_valid;
  logic [UNIT_W-1:0] cdb_tag;
  logic [WORD_W-1:0] cdb_val;

  logic [WORD_W-1:0] op_a;
  logic [WORD_W-1:0] op_b;
  logic [WORD_W-1:0] add_out;
  logic [WORD_W-1:0] mul_out;

  modport master (
    output rd_idx, wr_en, wr_idx, wr_tag, wr_val,
    output cdb_valid, cdb_tag, cdb_val, op_a, op_b,
    input  rd_tag, rd_val, add_out, mul_out
  );

  modport slave (
    input  rd_idx, wr_en, wr_idx, wr_tag, wr_val,
    input  cdb_valid, cdb_tag, cdb_val, op_a, op_b,
    output rd_tag, rd_val, add_out, mul_out
  );
endinterface

// File: rtl/reg_status_alu.sv
// Register status table (producer tag + value per architectural register) with
// common-data-bus wakeup, plus a stateless signed add/multiply unit.
module reg_status_alu #(
  parameter int unsigned       NREG      = 64,
  parameter int unsigned       UNIT_W    = 8,
  parameter int unsigned       WORD_W    = 32,
  parameter logic [UNIT_W-1:0] READY_TAG = UNIT_W'(8'h7F)
) (
  input  logic            clk,
  input  logic            rst_n,
  reg_status_alu_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(NREG);

  logic [UNIT_W-1:0] tag_q [NREG];
  logic [UNIT_W-1:0] tag_d [NREG];
  logic [WORD_W-1:0] val_q [NREG];
  logic [WORD_W-1:0] val_d [NREG];

  logic cdb_live;
  logic wr_ready;

  // A broadcast of the ready tag would otherwise overwrite every settled register.
  assign cdb_live = bus.cdb_valid && (bus.cdb_tag != READY_TAG);
  assign wr_ready = (bus.wr_tag == READY_TAG);

  // Broadcast first, then rename write, so a colliding rename keeps its tag.
  always_comb begin
    tag_d = tag_q;
    val_d = val_q;
    for (int i = 0; i < NREG; i++) begin
      if (cdb_live && (tag_q[i] == bus.cdb_tag)) begin
        tag_d[i] = READY_TAG;
        val_d[i] = bus.cdb_val;
      end
    end
    if (bus.wr_en) begin
      tag_d[bus.wr_idx] = bus.wr_tag;
      if (wr_ready) begin
        val_d[bus.wr_idx] = bus.wr_val;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        tag_q[i] <= READY_TAG;
        val_q[i] <= '0;
      end
    end else begin
      tag_q <= tag_d;
      val_q <= val_d;
    end
  end

  assign bus.rd_tag = tag_q[bus.rd_idx];
  assign bus.rd_val = val_q[bus.rd_idx];

  // Low word of a two's complement product is sign-independent; keep it signed for clarity.
  assign bus.add_out = WORD_W'(bus.op_a + bus.op_b);
  assign bus.mul_out = WORD_W'($signed(bus.op_a) * $signed(bus.op_b));

  logic unused_idx_w;
  assign unused_idx_w = ^IDX_W'(0);

endmodule

// File: tb/tb_reg_status_alu.sv
// Randomized bench for reg_status_alu against an array-based model of the status table.
module tb_reg_status_alu;

  localparam logic [7:0] RDY = 8'h7F;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  logic [7:0]  m_tag [64];
  logic [31:0] m_val [64];

  reg_status_alu_if #(.IDX_W(6), .UNIT_W(8), .WORD_W(32)) bus ();

  reg_status_alu dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // One clock with the given controls, then apply the same cycle to the model.
  task automatic step(input logic rst, input logic we, input logic [5:0] widx,
                      input logic [7:0] wtag, input logic [31:0] wval,
                      input logic cv, input logic [7:0] ctag, input logic [31:0] cval);
    bit hit [64];
    rst_n         = ~rst;
    bus.wr_en     = we;
    bus.wr_idx    = widx;
    bus.wr_tag    = wtag;
    bus.wr_val    = wval;
    bus.cdb_valid = cv;
    bus.cdb_tag   = ctag;
    bus.cdb_val   = cval;
    @(posedge clk);
    #1;
    if (rst) begin
      for (int i = 0; i < 64; i++) begin
        m_tag[i] = RDY;
        m_val[i] = 32'd0;
      end
    end else begin
      for (int i = 0; i < 64; i++) hit[i] = cv && (ctag != RDY) && (m_tag[i] == ctag);
      for (int i = 0; i < 64; i++) begin
        if (hit[i]) begin
          m_tag[i] = RDY;
          m_val[i] = cval;
        end
      end
      if (we) begin
        m_tag[widx] = wtag;
        if (wtag == RDY) m_val[widx] = wval;
      end
    end
    rst_n         = 1'b1;
    bus.wr_en     = 1'b0;
    bus.cdb_valid = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [5:0] idx,
                          input logic [7:0] etag, input logic [31:0] eval);
    bus.rd_idx = idx;
    @(negedge clk);
    check({tag, ".tag"}, 64'(bus.rd_tag), 64'(etag));
    check({tag, ".val"}, 64'(bus.rd_val), 64'(eval));
  endtask

  task automatic rd_model(input logic [5:0] idx);
    rd_check("rand_rd", idx, m_tag[idx], m_val[idx]);
  endtask

  task automatic alu_check(input string tag, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, sum, prod;
    bus.op_a = a;
    bus.op_b = b;
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    sum  = sa + sb;
    prod = sa * sb;
    @(negedge clk);
    check({tag, ".add"}, 64'(bus.add_out), 64'(sum[31:0]));
    check({tag, ".mul"}, 64'(bus.mul_out), 64'(prod[31:0]));
  endtask

  task automatic alu_const(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] eadd, input logic [31:0] emul, input bit chk_add);
    bus.op_a = a;
    bus.op_b = b;
    @(negedge clk);
    if (chk_add) check({tag, ".add"}, 64'(bus.add_out), 64'(eadd));
    check({tag, ".mul"}, 64'(bus.mul_out), 64'(emul));
  endtask

  logic [7:0] tag_pool [5];

  initial begin
    logic [7:0]  wt, ct;
    logic [31:0] wv, cv;
    logic [5:0]  wi;
    total = 0;
    bad   = 0;
    tag_pool[0] = 8'h10; tag_pool[1] = 8'h11; tag_pool[2] = 8'h12;
    tag_pool[3] = 8'h13; tag_pool[4] = RDY;
    rst_n = 1'b0;
    bus.rd_idx = '0; bus.op_a = '0; bus.op_b = '0;
    bus.wr_en = 1'b0; bus.wr_idx = '0; bus.wr_tag = '0; bus.wr_val = '0;
    bus.cdb_valid = 1'b0; bus.cdb_tag = '0; bus.cdb_val = '0;

    // Reset with live write/broadcast traffic must still clear everything.
    step(1'b1, 1'b1, 6'd7, 8'h10, 32'd5, 1'b1, 8'h10, 32'd9);
    step(1'b1, 1'b0, 6'd0, 8'h00, 32'd0, 1'b0, 8'h00, 32'd0);
    for (int i = 0; i < 64; i++) rd_check("reset", 6'(i), 8'h7F, 32'd0);

    step(1'b0, 1'b1, 6'd5, 8'h21, 32'd1234, 1'b0, 8'h00, 32'd0);
    rd_check("rename5", 6'd5, 8'h21, 32'd0);
    step(1'b0, 1'b0, 6'd0, 8'h00, 32'd0, 1'b1, 8'h21, 32'hFFFF_FFF9);
    rd_check("bcast5", 6'd5, 8'h7F, 32'hFFFF_FFF9);

    step(1'b0, 1'b1, 6'd3, 8'h7F, 32'd100, 1'b0, 8'h00, 32'd0);
    rd_check("imm3", 6'd3, 8'h7F, 32'd100);
    step(1'b0, 1'b1, 6'd1, 8'h42, 32'd0, 1'b0, 8'h00, 32'd0);
    step(1'b0, 1'b1, 6'd2, 8'h42, 32'd0, 1'b0, 8'h00, 32'd0);
    step(1'b0, 1'b0, 6'd0, 8'h00, 32'd0, 1'b1, 8'h42, 32'd55);
    rd_check("multi1", 6'd1, 8'h7F, 32'd55);
    rd_check("multi2", 6'd2, 8'h7F, 32'd55);
    rd_check("multi_other", 6'd3, 8'h7F, 32'd100);

    step(1'b0, 1'b0, 6'd0, 8'h00, 32'd0, 1'b1, 8'h7F, 32'd999);
    rd_check("ready_bcast", 6'd0, 8'h7F, 32'd0);

    step(1'b0, 1'b1, 6'd9, 8'h80, 32'd0, 1'b0, 8'h00, 32'd0);
    step(1'b0, 1'b1, 6'd9, 8'h81, 32'd77, 1'b1, 8'h80, 32'd12);
    rd_check("collide9", 6'd9, 8'h81, 32'd12);

    alu_const("ovf", 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 32'h7FFF_FFFF, 1'b1);
    alu_const("neg", 32'hFFFF_FFFD, 32'd4, 32'd1, 32'hFFFF_FFF4, 1'b1);
    alu_const("mulwrap", 32'h0001_0000, 32'h0001_0000, 32'h0002_0000, 32'd0, 1'b1);

    step(1'b0, 1'b1, 6'd4, 8'h22, 32'd0, 1'b0, 8'h00, 32'd0);
    rd_check("pre_rst4", 6'd4, 8'h22, 32'd0);
    step(1'b1, 1'b1, 6'd4, 8'h33, 32'd0, 1'b1, 8'h22, 32'd9);
    rd_check("rst4", 6'd4, 8'h7F, 32'd0);
    rd_check("rst5", 6'd5, 8'h7F, 32'd0);

    for (int n = 0; n < 1500; n++) begin
      wi = 6'($urandom_range(0, 63));
      wt = tag_pool[$urandom_range(0, 4)];
      ct = tag_pool[$urandom_range(0, 4)];
      wv = $urandom;
      cv = $urandom;
      step(($urandom_range(0, 99) == 0), 1'($urandom), wi, wt, wv, 1'($urandom), ct, cv);
      rd_model(wi);
      rd_model(6'($urandom_range(0, 63)));
      if (n % 8 == 0) alu_check("rand_alu", $urandom, $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_status_alu.md
REG_STATUS_ALU -- requirements
Module: reg_status_alu

Interface
REQ-001 Parameter NREG, default 64, number of architectural registers; the index width is log2(NREG) = 6.
REQ-002 Parameter UNIT_W, default 8, width of a producer-unit tag.
REQ-003 Parameter WORD_W, default 32, data word width (signed two's complement).
REQ-004 Parameter READY_TAG, default 8'h7F, tag meaning "register holds its final value".
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 rd_idx  input  6  register index for combinational lookup.
REQ-008 rd_tag  output  8  tag currently held by register rd_idx.
REQ-009 rd_val  output  32  value currently held by register rd_idx.
REQ-010 wr_en  input  1  rename write: retag register wr_idx.
REQ-011 wr_idx  input  6  register index for rename write.
REQ-012 wr_tag  input  8  new producer tag for wr_idx.
REQ-013 wr_val  input  32  value stored only when wr_tag == READY_TAG (immediate move).
REQ-014 cdb_valid  input  1  result broadcast strobe (common data bus).
REQ-015 cdb_tag  input  8  tag of the producing unit.
REQ-016 cdb_val  input  32  result value broadcast.
REQ-017 op_a, op_b  input  32 each  signed ALU operands.
REQ-018 add_out  output  32  op_a + op_b.
REQ-019 mul_out  output  32  op_a * op_b.

Function
REQ-020 The block SHALL hold NREG entries, each an 8-bit tag plus a 32-bit value.
REQ-021 rd_tag and rd_val SHALL be combinational reads of entry rd_idx's current registered state, with no bypass of same-cycle writes or broadcasts.
REQ-022 When cdb_valid=1, every entry whose tag equals cdb_tag SHALL, at the clock edge, take value cdb_val and tag READY_TAG.
REQ-023 A broadcast with cdb_tag == READY_TAG SHALL be ignored.
REQ-024 Entries whose tag differs from cdb_tag SHALL be unchanged by a broadcast.
REQ-025 When wr_en=1, entry wr_idx SHALL take tag wr_tag at the clock edge.
REQ-026 On a rename write, the value of entry wr_idx SHALL take wr_val if wr_tag == READY_TAG, and SHALL otherwise be retained.
REQ-027 In a cycle with both wr_en and cdb_valid, the broadcast SHALL be applied first, then the rename write.
REQ-028 When the rename write and the broadcast hit the same entry in one cycle, the rename write's tag SHALL be final.
REQ-029 With wr_en=0 and cdb_valid=0, state SHALL hold.
REQ-030 add_out SHALL be combinational: (op_a + op_b) mod 2^32, with overflow wrapping silently.
REQ-031 mul_out SHALL be combinational: the low 32 bits of the signed 64-bit product op_a*op_b.
REQ-032 Update latency SHALL be one cycle: a change is visible on rd_* the cycle after the edge.

Reset
REQ-033 While rst_n=0 at a rising edge, all entries SHALL become tag READY_TAG and value 0.
REQ-034 rst_n=0 SHALL override wr_en and cdb_valid in the same cycle.
REQ-035 add_out and mul_out have no state; they SHALL be valid whenever the operands are.

Verification
REQ-036 Reset, then read rd_idx=0..63 -> every entry returns rd_tag=8'h7F, rd_val=0.
REQ-037 Rename then broadcast:
- wr_en, wr_idx=5, wr_tag=8'h21 -> rd_tag=8'h21, value unchanged.
- then cdb_valid, cdb_tag=8'h21, cdb_val=-7 -> rd_tag=8'h7F, rd_val=32'hFFFFFFF9.
REQ-038 Immediate move and multi-entry broadcast:
- wr_en, wr_idx=3, wr_tag=8'h7F, wr_val=100 -> rd_val=100.
- regs 1 and 2 both tagged 8'h42, broadcast 8'h42/55 -> both entries ready with value 55.
REQ-039 Same-cycle collision: reg 9 tagged 8'h80; in one cycle broadcast 8'h80/12 and rename reg 9 to 8'h81 -> rd_tag=8'h81, rd_val=12.
REQ-040 ALU arithmetic:
- op_a=32'h7FFFFFFF, op_b=1 -> add_out=32'h80000000.
- op_a=-3, op_b=4 -> add_out=1, mul_out=-12.
- op_a=32'h10000, op_b=32'h10000 -> mul_out=0.
REQ-041 Mid-operation reset: reg 4 tagged 8'h22, assert rst_n=0 together with cdb_valid 8'h22/9 -> reg 4 reads tag 8'h7F, value 0.
